// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared types and constants for the systolic-array output drain
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    FLUSH,
    DONE
  } drain_state_t;

  // Memory enables are active-low
  localparam logic MEM_EN  = 1'b0;
  localparam logic MEM_DIS = 1'b1;

endpackage

// File: rtl/sa_drain_fifo.sv
// rtl/sa_drain_fifo.sv - small synchronous FIFO buffering output-memory read data
module sa_drain_fifo #(
  parameter int ROW_WIDTH  = 128,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  logic                               pop,
  input  logic [ROW_WIDTH-1:0]               din,
  output logic [ROW_WIDTH-1:0]               dout,
  output logic                               empty,
  output logic                               full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);

  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH+1);

  logic [ROW_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [ROW_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic                 do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNTW'(FIFO_DEPTH));
  assign count = cnt_q;
  assign dout  = mem_q[rd_ptr_q];

  // Pop only real entries; a push into a full FIFO is allowed when a pop frees the slot
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CNTW'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CNTW'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/sa_output_drain.sv
// rtl/sa_output_drain.sv - streams result rows out of the systolic-array output memory
module sa_output_drain
  import sa_pkg::*;
#(
  parameter int ADD_DATAWIDTH = 32,
  parameter int NUM_COLS      = 4,
  parameter int MEM_ROWS      = 8,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_start,
  input  logic [$clog2(MEM_ROWS):0]           i_row_count,
  output logic                                o_busy,
  output logic                                o_done,
  output logic                                o_mem_cenb,
  output logic                                o_mem_wenb,
  output logic [$clog2(MEM_ROWS)-1:0]         o_mem_addr,
  input  logic [ADD_DATAWIDTH*NUM_COLS-1:0]   i_mem_data,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic [ADD_DATAWIDTH*NUM_COLS-1:0]   o_data,
  output logic                                o_last
);

  localparam int ROW_WIDTH = ADD_DATAWIDTH*NUM_COLS;
  localparam int AW        = $clog2(MEM_ROWS);
  localparam int CW        = AW + 1;
  localparam int FCW       = $clog2(FIFO_DEPTH+1);
  localparam int OW        = FCW + 1;

  drain_state_t   state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  rd_addr_q, rd_addr_d;
  logic [CW-1:0]  beat_q, beat_d;
  logic           inflight_q, inflight_d;
  logic [AW-1:0]  addr_q, addr_d;

  logic [ROW_WIDTH-1:0] fifo_dout;
  logic                 fifo_empty, fifo_full;
  logic [FCW-1:0]       fifo_count;
  logic                 pop, issue, credit_ok;
  logic [OW-1:0]        outstanding;
  logic [CW-1:0]        clamped_count;

  sa_drain_fifo #(
    .ROW_WIDTH (ROW_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (inflight_q),
    .pop  (pop),
    .din  (i_mem_data),
    .dout (fifo_dout),
    .empty(fifo_empty),
    .full (fifo_full),
    .count(fifo_count)
  );

  assign pop = !fifo_empty && i_ready;

  // Rows buffered plus the one in flight, less the row leaving this cycle, must leave a slot
  assign outstanding = {1'b0, fifo_count} + OW'(inflight_q) - OW'(pop);
  assign credit_ok   = (outstanding < OW'(FIFO_DEPTH)) && (!fifo_full || pop);
  assign issue       = (state_q == READ) && (rd_addr_q < count_q) && credit_ok;

  assign clamped_count = (i_row_count > CW'(MEM_ROWS)) ? CW'(MEM_ROWS) : i_row_count;

  assign o_mem_cenb = issue ? MEM_EN : MEM_DIS;
  assign o_mem_wenb = MEM_DIS;
  assign o_mem_addr = issue ? rd_addr_q[AW-1:0] : addr_q;
  assign o_valid    = !fifo_empty;
  assign o_data     = fifo_empty ? '0 : fifo_dout;
  assign o_last     = o_valid && (beat_q == count_q - CW'(1));
  assign o_busy     = (state_q != IDLE);

  // Next-state, counters and done pulse
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_addr_d  = rd_addr_q;
    beat_d     = beat_q;
    addr_d     = addr_q;
    inflight_d = issue;
    o_done     = 1'b0;
    if (pop) begin
      beat_d = beat_q + CW'(1);
    end
    if (issue) begin
      rd_addr_d = rd_addr_q + CW'(1);
      addr_d    = rd_addr_q[AW-1:0];
    end
    case (state_q)
      IDLE: begin
        if (i_start) begin
          count_d   = clamped_count;
          rd_addr_d = '0;
          beat_d    = '0;
          state_d   = (clamped_count == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (issue && (rd_addr_q == count_q - CW'(1))) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!inflight_q && pop && (beat_q == count_q - CW'(1))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        o_done    = 1'b1;
        state_d   = IDLE;
        count_d   = '0;
        rd_addr_d = '0;
        beat_d    = '0;
        addr_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rd_addr_q  <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_addr_q  <= rd_addr_d;
      beat_q     <= beat_d;
      inflight_q <= inflight_d;
      addr_q     <= addr_d;
    end
  end

endmodule

// File: tb/tb_sa_output_drain.sv
// tb/tb_sa_output_drain.sv - scoreboard bench for sa_output_drain
module tb_sa_output_drain;

  localparam int RW = 128;

  typedef struct {
    logic [RW-1:0] data;
    bit            last;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [3:0]    i_row_count = '0;
  logic          o_busy, o_done, o_mem_cenb, o_mem_wenb;
  logic [2:0]    o_mem_addr;
  logic [RW-1:0] i_mem_data = '0;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic [RW-1:0] o_data;
  logic          o_last;

  logic [RW-1:0] rows [8];
  exp_t          exp_q [$];
  int            n_pass = 0, n_chk = 0;
  int            cyc = 0, t0 = 0;
  int            issued = 0, popped = 0;
  int            beats_seen = 0, valid_cycles = 0, cenb_lows = 0;
  int            done_cnt = 0, done_cyc = 0;
  bit            stall_prev = 1'b0;
  logic [RW-1:0] prev_data = '0;
  bit            pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  sa_output_drain dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_row_count(i_row_count),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_mem_cenb (o_mem_cenb),
    .o_mem_wenb (o_mem_wenb),
    .o_mem_addr (o_mem_addr),
    .i_mem_data (i_mem_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_last     (o_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output memory model: one-cycle read latency
  always @(posedge clk) begin
    if (!o_mem_cenb) i_mem_data <= rows[o_mem_addr];
  end

  function automatic logic [RW-1:0] row(input int k);
    return {32'(k), 32'(k + 1), 32'(k + 2), 32'(k + 3)};
  endfunction

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on each handshake and checks protocol rules
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      issued = 0;
      popped = 0;
      stall_prev = 1'b0;
    end else begin
      automatic bit pop_now = o_valid && i_ready;
      if (!o_mem_cenb) begin
        cenb_lows++;
        chk("credit", RW'((issued - popped - int'(pop_now)) < 2), RW'(1));
        chk("wenb", RW'(o_mem_wenb), RW'(1));
      end
      if (o_valid) valid_cycles++;
      if (stall_prev) begin
        chk("stall_valid", RW'(o_valid), RW'(1));
        chk("stall_data", o_data, prev_data);
      end
      if (pop_now) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          chk("extra_beat", RW'(beats_seen), RW'(0));
        end else begin
          automatic exp_t e = exp_q.pop_front();
          chk("beat_data", o_data, e.data);
          chk("beat_last", RW'(o_last), RW'(e.last));
          if (e.cyc >= 0) chk("beat_cycle", RW'(cyc - t0), RW'(e.cyc));
        end
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      issued += int'(!o_mem_cenb);
      popped += int'(pop_now);
      stall_prev = o_valid && !i_ready;
      prev_data = o_data;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, RW'(o_busy), RW'(0));
    chk({tag, "_done"}, RW'(o_done), RW'(0));
    chk({tag, "_valid"}, RW'(o_valid), RW'(0));
    chk({tag, "_last"}, RW'(o_last), RW'(0));
    chk({tag, "_data"}, o_data, RW'(0));
    chk({tag, "_cenb"}, RW'(o_mem_cenb), RW'(1));
    chk({tag, "_wenb"}, RW'(o_mem_wenb), RW'(1));
    chk({tag, "_addr"}, RW'(o_mem_addr), RW'(0));
  endtask

  task automatic drain(input int n, input bit bp, input int busy_at,
                       input int exp_beats, input int exp_done_rel);
    int b0, d0, v0, c0;
    b0 = beats_seen; d0 = done_cnt; v0 = valid_cycles; c0 = cenb_lows;
    for (int k = 0; k < exp_beats; k++) begin
      exp_q.push_back('{row(k), (k == exp_beats - 1), bp ? -1 : 3 + k});
    end
    @(posedge clk); #1;
    i_start = 1'b1; i_row_count = 4'(n); i_ready = 1'b1; t0 = cyc;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      i_start = (c == busy_at);
      if (c == busy_at) i_row_count = 4'd2;
      i_ready = bp ? pat[c % 4] : 1'b1;
      if (done_cnt != d0) break;
    end
    i_start = 1'b0;
    i_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("done_count", RW'(done_cnt - d0), RW'(1));
    if (exp_done_rel >= 0) chk("done_cycle", RW'(done_cyc - t0), RW'(exp_done_rel));
    chk("beat_count", RW'(beats_seen - b0), RW'(exp_beats));
    chk("sb_empty", RW'(exp_q.size()), RW'(0));
    if (exp_beats == 0) begin
      chk("zero_valid", RW'(valid_cycles - v0), RW'(0));
      chk("zero_cenb", RW'(cenb_lows - c0), RW'(0));
    end
    check_idle_outputs("post");
  endtask

  initial begin
    for (int k = 0; k < 8; k++) rows[k] = row(k);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    drain(8, 1'b0, -1, 8, 11);
    drain(5, 1'b1, -1, 5, -1);
    drain(0, 1'b0, -1, 0, 1);
    drain(12, 1'b0, -1, 8, 11);
    drain(6, 1'b0, 4, 6, 9);

    // Reset in cycle 5 of an 8-row drain
    begin
      int d0;
      d0 = done_cnt;
      for (int k = 0; k < 8; k++) exp_q.push_back('{row(k), (k == 7), 3 + k});
      @(posedge clk); #1;
      i_start = 1'b1; i_row_count = 4'd8; i_ready = 1'b1; t0 = cyc;
      for (int c = 1; c <= 5; c++) begin
        @(posedge clk); #1;
        i_start = 1'b0;
        if (c == 5) rst = 1'b1;
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("midrst");
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("midrst_no_done", RW'(done_cnt - d0), RW'(0));
      chk("midrst_valid", RW'(o_valid), RW'(0));
    end

    drain(3, 1'b0, -1, 3, 6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
